nx_msg_decoder: RTL

Receive-side message decoder for a logic node. It accepts the node's inbound byte stream from the mesh, one CMD_W-bit flit per cycle, and checks the leading target byte against the node's ID. Messages addressed to this node are assembled into the command/payload/valid/complete form consumed by node control. All other messages are forwarded unchanged on a bypass output.

---
 rtl/nx_msg_decoder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/nx_msg_decoder.sv
// rtl/nx_msg_decoder.sv - inbound message decoder: local assembly or bypass forwarding
// Optional feature macro: NX_MSG_DECODER_BROADCAST_EN (all-ones target is accepted as local)
module nx_msg_decoder #(
    parameter int TARGET_W  = 8,
    parameter int CMD_W     = 8,
    parameter int PAYLOAD_W = 24,
    parameter int VALID_W   = PAYLOAD_W / CMD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TARGET_W-1:0]  node_id,
    input  logic [CMD_W-1:0]     in_data,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CMD_W-1:0]     byp_data,
    output logic                 byp_last,
    output logic                 byp_valid,
    input  logic                 byp_ready,
    output logic [CMD_W-1:0]     rx_command,
    output logic [PAYLOAD_W-1:0] rx_payload,
    output logic [VALID_W-1:0]   rx_valid,
    output logic                 rx_complete,
    input  logic                 rx_ready,
    output logic                 err_overflow,
    output logic                 err_short
);

    // counter must be able to reach VALID_W to detect overflow
    localparam int CW = $clog2(VALID_W + 1);
    localparam logic [CW-1:0] L_VMAX = CW'(VALID_W);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_PAYLOAD, S_HOLD, S_FWD_HDR, S_FWD, S_DROP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [TARGET_W-1:0]    r_target;
    logic                   r_tlast;
    logic [CW-1:0]          r_cnt;
    logic [CMD_W-1:0]       r_command;
    logic [PAYLOAD_W-1:0]   r_payload;
    logic [VALID_W-1:0]     r_valid;
    logic                   r_err_ovf;
    logic                   r_err_short;
    logic [CMD_W-1:0]       r_byp_data;
    logic                   r_byp_last;
    logic                   r_byp_valid;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_match;
    logic                   w_byp_free;
    logic                   w_cnt_full;
    logic                   w_byp_load;
    logic [CMD_W-1:0]       w_byp_ld_data;
    logic                   w_byp_ld_last;

`ifdef NX_MSG_DECODER_BROADCAST_EN
    assign w_match = (in_data == node_id) || (in_data == {TARGET_W{1'b1}});
`else
    assign w_match = (in_data == node_id);
`endif

    // bypass slot can take a new flit when empty or being drained this cycle
    assign w_byp_free = !r_byp_valid || byp_ready;
    assign w_cnt_full = (r_cnt == L_VMAX);
    assign w_in_ready = (r_state == S_HOLD || r_state == S_FWD_HDR) ? 1'b0 :
                        (r_state == S_FWD) ? w_byp_free : 1'b1;
    assign w_accept   = in_valid && w_in_ready;

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next-state decode and bypass load selection
    always_comb begin
        w_next        = r_state;
        w_byp_load    = 1'b0;
        w_byp_ld_data = in_data;
        w_byp_ld_last = in_last;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (w_match) w_next = in_last ? S_IDLE : S_CMD;
                else         w_next = S_FWD_HDR;
            end
            S_CMD: if (w_accept) w_next = in_last ? S_HOLD : S_PAYLOAD;
            S_PAYLOAD: if (w_accept) begin
                if (in_last)         w_next = S_HOLD;
                else if (w_cnt_full) w_next = S_DROP;
            end
            S_DROP: if (w_accept && in_last) w_next = S_HOLD;
            S_HOLD: if (rx_ready) w_next = S_IDLE;
            S_FWD_HDR: if (w_byp_free) begin
                w_byp_load    = 1'b1;
                w_byp_ld_data = r_target;
                w_byp_ld_last = r_tlast;
                w_next        = r_tlast ? S_IDLE : S_FWD;
            end
            S_FWD: if (w_accept) begin
                w_byp_load = 1'b1;
                if (in_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // header capture, message assembly and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target    <= '0;
            r_tlast     <= 1'b0;
            r_cnt       <= '0;
            r_command   <= '0;
            r_payload   <= '0;
            r_valid     <= '0;
            r_err_ovf   <= 1'b0;
            r_err_short <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    r_target <= in_data;
                    r_tlast  <= in_last;
                    if (w_match && in_last) r_err_short <= 1'b1;
                end
                S_CMD: begin
                    r_command <= in_data;
                    r_payload <= '0;
                    r_valid   <= '0;
                    r_cnt     <= '0;
                end
                S_PAYLOAD: begin
                    if (w_cnt_full) begin
                        r_err_ovf <= 1'b1;
                    end else begin
                        for (int i = 0; i < VALID_W; i++) begin
                            if (r_cnt == CW'(i)) begin
                                r_payload[i*CMD_W +: CMD_W] <= in_data;
                                r_valid[i]                  <= 1'b1;
                            end
                        end
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // single-stage bypass register; holds steady while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp_data  <= '0;
            r_byp_last  <= 1'b0;
            r_byp_valid <= 1'b0;
        end else if (w_byp_load) begin
            r_byp_data  <= w_byp_ld_data;
            r_byp_last  <= w_byp_ld_last;
            r_byp_valid <= 1'b1;
        end else if (byp_ready) begin
            r_byp_valid <= 1'b0;
        end
    end

    assign in_ready     = w_in_ready;
    assign byp_data     = r_byp_data;
    assign byp_last     = r_byp_last;
    assign byp_valid    = r_byp_valid;
    assign rx_command   = r_command;
    assign rx_payload   = r_payload;
    assign rx_valid     = r_valid;
    assign rx_complete  = (r_state == S_HOLD);
    assign err_overflow = r_err_ovf;
    assign err_short    = r_err_short;

endmodule
